fpga1_decoder: RTL and testbench

- Registered hexadecimal-to-7-segment decoder for the FPGA board display path.
- Samples a 4-bit nibble each clock and drives one seven-segment digit with the corresponding glyph, 0-9 and A-F.
- Sits between the board switches/logic and the display pins; it contains no other state than the output register.

---
 rtl/fpga1_decoder.sv | 60 ++++++
 tb/tb_fpga1_decoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fpga1_decoder.sv
// rtl/fpga1_decoder.sv - registered hex-to-seven-segment decoder
// Output bit order is {g,f,e,d,c,b,a}; COMMON_ANODE selects active-low drive.
module fpga1_decoder #(
  parameter int COMMON_ANODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] entrada,
  output logic [6:0] saida
);

  localparam logic [6:0] SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;

  logic [6:0] glyph;
  logic [6:0] saida_d;
  logic [6:0] saida_q;

  // Active-high glyph table; polarity is applied afterwards.
  always_comb begin
    glyph = 7'h00;
    unique case (entrada)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
  end

  always_comb begin
    saida_d = glyph;
    if (COMMON_ANODE != 0) begin
      saida_d = ~glyph;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      saida_q <= SEG_OFF;
    end else begin
      saida_q <= saida_d;
    end
  end

  assign saida = saida_q;

endmodule

// File: tb/tb_fpga1_decoder.sv
// tb/tb_fpga1_decoder.sv - directed bench for fpga1_decoder, both polarities
module tb_fpga1_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] entrada;
  logic [6:0] saida_ca;
  logic [6:0] saida_cc;

  int checks;
  int failures;

  logic [6:0] tab_cc [16];
  logic [6:0] tab_ca [16];

  fpga1_decoder #(.COMMON_ANODE(1)) u_dut_ca (
    .clk     (clk),
    .rst_n   (rst_n),
    .entrada (entrada),
    .saida   (saida_ca)
  );

  fpga1_decoder #(.COMMON_ANODE(0)) u_dut_cc (
    .clk     (clk),
    .rst_n   (rst_n),
    .entrada (entrada),
    .saida   (saida_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_both(input string tag, input logic [3:0] v);
    check({tag, "_ca"}, saida_ca, tab_ca[v]);
    check({tag, "_cc"}, saida_cc, tab_cc[v]);
  endtask

  task automatic check_off(input string tag);
    check({tag, "_ca"}, saida_ca, 7'h7F);
    check({tag, "_cc"}, saida_cc, 7'h00);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    tab_cc = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    tab_ca = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Power-up: reset is asynchronous, so the off pattern appears before any edge.
    rst_n   = 1'b1;
    entrada = 4'h0;
    #2;
    check_off("reset_async");
    next_edge();
    check_off("reset_edge");
    rst_n = 1'b0;
    check_off("release_pending");
    next_edge();
    check("first_ca", saida_ca, 7'h40);
    check("first_cc", saida_cc, 7'h3F);
    for (int i = 0; i < 10; i++) begin
      next_edge();
      check_both("hold0", 4'h0);
    end

    // Sweep with 1-cycle lag: new input invisible until the edge.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] prev;
      prev    = (i == 0) ? 4'h0 : 4'(i - 1);
      entrada = 4'(i);
      #1;
      check_both("sweep_pre", prev);
      next_edge();
      check_both("sweep", 4'(i));
    end

    // Mid-cycle reset while showing 7.
    entrada = 4'h7;
    next_edge();
    check_both("show7", 4'h7);
    #3;
    rst_n = 1'b1;
    #1;
    check_off("midreset");
    entrada = 4'h2;
    next_edge();
    check_off("midreset_edge");
    rst_n = 1'b0;
    next_edge();
    check_both("resume2", 4'h2);

    // Several changes within one cycle: only the edge value counts.
    entrada = 4'h3;
    #2;
    entrada = 4'h5;
    #2;
    entrada = 4'h9;
    #1;
    check_both("toggle_pre", 4'h2);
    next_edge();
    check("toggle9_ca", saida_ca, 7'h10);
    check("toggle9_cc", saida_cc, 7'h6F);

    // Reset held across edges while input moves.
    rst_n = 1'b1;
    #1;
    check_off("hold_rst_async");
    for (int i = 0; i < 5; i++) begin
      entrada = 4'(4'hA + i);
      next_edge();
      check_off("hold_rst");
    end
    entrada = 4'hE;
    rst_n   = 1'b0;
    next_edge();
    check_both("after_hold", 4'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
